// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and constants for the sysid boot checker: FSM encoding,
// sysid slave word addresses and the default expected words.
package sysid_boot_checker_pkg;

    typedef enum logic [2:0] {
        DELAY,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1513050915;

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the sysid slave.
// Handshake: a read is accepted on any cycle where avm_read=1 and avm_waitrequest=0;
// the master holds avm_address and avm_read stable while avm_waitrequest=1.
interface sysid_boot_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/sysid_boot_checker_avm_single_read.sv
// One Avalon-MM read: waitrequest hold, fixed read-latency window and per-read timeout.
// accept/rvalid/tmo are single-cycle strobes; rdata is meaningful only with rvalid.
module avm_single_read
    import sysid_boot_checker_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic                 addr,
    sysid_boot_checker_if.master avm,
    output logic [31:0]          rdata,
    output logic                 accept,
    output logic                 rvalid,
    output logic                 tmo
);

    localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic        pending;
    logic [1:0]  lat_cnt;
    logic [15:0] tmo_cnt;

    assign accept = avm.avm_read & ~avm.avm_waitrequest;
    assign tmo    = avm.avm_read & avm.avm_waitrequest & (tmo_cnt == TMO_LAST);
    assign rvalid = (READ_LATENCY == 0) ? accept : (pending && (lat_cnt == LAT_LAST));
    assign rdata  = avm.avm_readdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            avm.avm_read    <= 1'b0;
            avm.avm_address <= SYSID_ADDR_ID;
            pending         <= 1'b0;
            lat_cnt         <= 2'd0;
            tmo_cnt         <= 16'd0;
        end else begin
            // A new request wins over the accept of the previous one so
            // back-to-back reads keep avm_read high with the new address.
            if (go) begin
                avm.avm_read    <= 1'b1;
                avm.avm_address <= addr;
                tmo_cnt         <= 16'd0;
            end else if (avm.avm_read) begin
                if (!avm.avm_waitrequest) begin
                    avm.avm_read <= 1'b0;
                    if (READ_LATENCY != 0) begin
                        pending <= 1'b1;
                        lat_cnt <= 2'd1;
                    end
                end else if (tmo) begin
                    avm.avm_read <= 1'b0;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
            end
            if (pending) begin
                if (lat_cnt == LAT_LAST) begin
                    pending <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sysid check: reads ID and timestamp words after reset or on start,
// latches them and reports match/timeout status with registered outputs.
module sysid_boot_checker
    import sysid_boot_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int          READ_LATENCY   = 0,
    parameter int          START_DELAY    = 16,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    sysid_boot_checker_if.master avm,
    output logic [31:0]          id_value,
    output logic [31:0]          ts_value,
    output logic                 busy,
    output logic                 done,
    output logic                 id_match,
    output logic                 ts_match,
    output logic                 timeout,
    output state_t               state
);

    localparam logic [7:0] DELAY_LAST = 8'(START_DELAY - 1);

    logic [7:0]  delay_cnt;
    logic        go;
    logic        rd_addr;
    logic        in_id;
    logic        accept;
    logic        rvalid;
    logic        tmo;
    logic [31:0] rdata;

    assign in_id   = (state == RD_ID) || (state == LAT_ID);
    assign rd_addr = in_id ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    // Read launches: end of the start delay, a start pulse in DONE, or the
    // ID word arriving (TS read follows with no idle cycle).
    assign go = ((state == DELAY) && (delay_cnt == DELAY_LAST)) ||
                ((state == DONE) && done && start) ||
                (in_id && rvalid);

    avm_single_read #(
        .READ_LATENCY  (READ_LATENCY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_read (
        .clock (clock),
        .reset (reset),
        .go    (go),
        .addr  (rd_addr),
        .avm   (avm),
        .rdata (rdata),
        .accept(accept),
        .rvalid(rvalid),
        .tmo   (tmo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= DELAY;
            delay_cnt <= 8'd0;
            id_value  <= 32'd0;
            ts_value  <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            id_match  <= 1'b0;
            ts_match  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                DELAY: begin
                    busy <= 1'b1;
                    if (delay_cnt == DELAY_LAST) begin
                        delay_cnt <= 8'd0;
                        state     <= RD_ID;
                    end else begin
                        delay_cnt <= delay_cnt + 8'd1;
                    end
                end
                RD_ID, LAT_ID: begin
                    if (rvalid) begin
                        id_value <= rdata;
                        state    <= RD_TS;
                    end else if (accept) begin
                        state <= LAT_ID;
                    end else if (tmo) begin
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        id_match <= 1'b0;
                        ts_match <= 1'b0;
                        state    <= DONE;
                    end
                end
                RD_TS, LAT_TS: begin
                    if (rvalid) begin
                        ts_value <= rdata;
                        state    <= DONE;
                    end else if (accept) begin
                        state <= LAT_TS;
                    end else if (tmo) begin
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        id_match <= 1'b0;
                        ts_match <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle of a normal run publishes the compares
                    // of the now-latched words together with done.
                    if (!done) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        id_match <= (id_value == EXPECTED_ID);
                        ts_match <= (ts_value == EXPECTED_TS);
                    end else if (start) begin
                        done     <= 1'b0;
                        id_match <= 1'b0;
                        ts_match <= 1'b0;
                        timeout  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RD_ID;
                    end
                end
                default: state <= DELAY;
            endcase
        end
    end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
Avalon-MM master that reads the system-ID slave (address 0 = ID word, address 1 = build timestamp) after reset or on request. Latches both words and compares them with build-time expected values. Raises pass/fail/timeout status for the top-level LED/HEX logic and the NIOS-less bring-up path. Sits directly upstream of the sysid slave, driving its address and read and consuming its readdata.

Parameters:
EXPECTED_ID, 32'h0000_0000, ID word expected at address 0
EXPECTED_TS, 32'd1513050915, timestamp expected at address 1
READ_LATENCY, 0, cycles from accepted read to valid readdata (0 = same cycle; legal 0..3)
START_DELAY, 16, cycles after reset deassert before the auto-start (legal 1..255)
TIMEOUT_CYCLES, 255, maximum cycles with waitrequest high per read before abort (legal 1..65535)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to re-run the check; ignored while busy
avm_address  out  1  slave word address
avm_read  out  1  read strobe
avm_readdata  in  32  slave read data
avm_waitrequest  in  1  slave stall; tie 0 for the sysid slave
id_value  out  32  latched ID word
ts_value  out  32  latched timestamp word
busy  out  1  check sequence in progress
done  out  1  sequence finished (sticky until next start)
id_match  out  1  id_value == EXPECTED_ID (valid when done)
ts_match  out  1  ts_value == EXPECTED_TS (valid when done)
timeout  out  1  a read exceeded TIMEOUT_CYCLES

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clock. Reset values: avm_read=0, avm_address=0, id_value=0, ts_value=0, busy=0, done=0, id_match=0, ts_match=0, timeout=0, FSM=DELAY, delay counter=0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: DELAY, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.
- DELAY:
  - busy=1. Count START_DELAY cycles, then enter RD_ID.
  - start is ignored in DELAY.
- RD_ID:
  - avm_address=0, avm_read=1. Hold both stable while avm_waitrequest=1.
  - On the cycle with avm_read=1 and waitrequest=0, the read is accepted and avm_read drops on the next edge.
  - If READ_LATENCY=0, capture avm_readdata into id_value in the accepting cycle and go to RD_TS.
  - Otherwise go to LAT_ID.
- LAT_ID: count READ_LATENCY cycles from acceptance. Capture readdata on the READ_LATENCY-th cycle after acceptance, then go to RD_TS.
- RD_TS and LAT_TS: identical to RD_ID and LAT_ID with avm_address=1, capturing into ts_value. Then go to DONE.
- Per-read timeout counter:
  - Clears on entering RD_ID or RD_TS and increments each cycle waitrequest=1.
  - When it reaches TIMEOUT_CYCLES: drop avm_read, set timeout=1, set done=1, force id_match=0 and ts_match=0, and go to DONE. Latched values captured so far are kept.
- Entering DONE (normal path): busy=0, done=1. id_match and ts_match are registered compares of the latched words, valid in the same cycle that done rises.
- DONE with start=1:
  - Clear done, id_match, ts_match and timeout, and set busy=1. id_value and ts_value are kept until overwritten.
  - Next state is RD_ID; no delay.
- start asserted in any state other than DONE has no effect. Each run needs a fresh pulse in DONE.
- Reset asserted mid-read: avm_read drops on that edge. Any pending latency-window data is discarded and the sequence restarts from DELAY.
- Timing: with READ_LATENCY=0 and waitrequest tied 0, the run lasts START_DELAY + 2 cycles of RD_* plus 1 cycle to DONE. done rises START_DELAY+3 cycles after reset deasserts.

Decomposition:
- Shared package holds:
  - FSM state enum: DELAY, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.
  - Address constants: SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1.
  - Default expected-value constants.
- One natural sub-module, avm_single_read: drives one Avalon read with waitrequest hold, latency counting and timeout. It returns rdata, rvalid and tmo.
- Top FSM instantiates it once and sequences the two addresses.

Test Plan:
- Sysid slave model (address?1513050915:0), waitrequest=0, READ_LATENCY=0, defaults -> done at cycle START_DELAY+3 after reset; id_value=0, ts_value=1513050915, id_match=1, ts_match=1, timeout=0.
- Slave returns ts 32'h5A2F_0000 -> done=1, id_match=1, ts_match=0, ts_value=32'h5A2F_0000.
- waitrequest high 5 cycles on each read, READ_LATENCY=2 -> address and read held stable during the stall; values captured 2 cycles after acceptance; both matches=1.
- waitrequest stuck high, TIMEOUT_CYCLES=8 -> avm_read drops after 8 stalled cycles; timeout=1, done=1, matches=0, ts_value=0.
- After done, pulse start; also pulse start during DELAY -> second run begins only from the DONE pulse; done low for exactly the run duration; results re-established.
- Reset asserted during LAT_TS -> avm_read=0 and all status cleared on the next edge; sequence restarts from DELAY and completes normally.
